// File: rtl/fsk_pkg.sv
// Shared types and defaults for the FSK transmit/receive path.
package fsk_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PREAMBLE,
        SYNC,
        LENGTH,
        PAYLOAD
    } fsk_state_e;

    localparam int          BIT_PERIOD_DEFAULT = 3600;
    localparam logic [31:0] SYNC_WORD_DEFAULT  = 32'h0000_D391;

    // Left-justify the active sync bits so an MSB-first shifter always reads bit 31.
    function automatic logic [31:0] sync_align(input logic [31:0] word, input int len);
        return word << (32 - len);
    endfunction

endpackage

// File: rtl/fsk_tx_framer_if.sv
// Byte-wide valid/ready payload stream feeding the FSK frame sequencer.
interface fsk_tx_framer_if;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;

    modport master (output in_data, output in_valid, input  in_ready);
    modport slave  (input  in_data, input  in_valid, output in_ready);
endinterface

// File: rtl/fsk_bit_timer.sv
// Bit-period counter: counts 0..BIT_PERIOD-1 while enabled and flags the last cycle.
module fsk_bit_timer
    import fsk_pkg::*;
#(
    parameter int BIT_PERIOD = BIT_PERIOD_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic wrap
);
    localparam int W = (BIT_PERIOD > 1) ? $clog2(BIT_PERIOD) : 1;

    logic [W-1:0] cnt;

    assign wrap = en && (cnt == W'(BIT_PERIOD - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (en)
            cnt <= wrap ? '0 : cnt + W'(1);
    end
endmodule

// File: rtl/fsk_tx_framer.sv
// Frame sequencer for the FSK modulator: preamble, sync word, length byte, payload bytes.
module fsk_tx_framer
    import fsk_pkg::*;
#(
    parameter int          BIT_PERIOD    = BIT_PERIOD_DEFAULT,
    parameter int          PREAMBLE_BITS = 16,
    parameter int          SYNC_LEN      = 16,
    parameter logic [31:0] SYNC_WORD     = SYNC_WORD_DEFAULT,
    parameter logic        IDLE_LEVEL    = 1'b0
) (
    input  logic            bb_clk,
    input  logic            rst,
    input  logic            start,
    input  logic [7:0]      len,
    fsk_tx_framer_if.slave  in_if,
    output logic            bit_out,
    output logic            tx_active,
    output logic            bit_strobe,
    output logic            done,
    output logic            underrun
);
    localparam logic [31:0] SYNC_ALIGNED = sync_align(SYNC_WORD, SYNC_LEN);
    localparam logic [15:0] PRE_LAST     = 16'(PREAMBLE_BITS - 1);
    localparam logic [15:0] SYNC_LAST    = 16'(SYNC_LEN - 1);

    fsk_state_e  state_q, state_d;
    logic [7:0]  len_q, len_d;
    logic [31:0] sh_q, sh_d;
    logic [15:0] idx_q, idx_d;
    logic [7:0]  hold_q, hold_d;
    logic        full_q, full_d;
    logic [7:0]  fetched_q, fetched_d;
    logic [7:0]  loaded_q, loaded_d;
    logic        bit_d, active_d, strobe_d, done_d, under_d;
    logic        wrap, last_bit, accept;

    fsk_bit_timer #(.BIT_PERIOD(BIT_PERIOD)) u_timer (
        .clk  (bb_clk),
        .rst  (rst),
        .en   (state_q != IDLE),
        .clr  (state_q == IDLE),
        .wrap (wrap)
    );

    assign in_if.in_ready = !full_q && (state_q inside {SYNC, LENGTH, PAYLOAD}) && (fetched_q < len_q);
    assign accept         = in_if.in_valid && in_if.in_ready;

    always_comb begin
        last_bit = 1'b0;
        case (state_q)
            PREAMBLE:        last_bit = (idx_q == PRE_LAST);
            SYNC:            last_bit = (idx_q == SYNC_LAST);
            LENGTH, PAYLOAD: last_bit = (idx_q == 16'd7);
            default:         last_bit = 1'b0;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        sh_d      = sh_q;
        idx_d     = idx_q;
        hold_d    = hold_q;
        full_d    = full_q;
        fetched_d = fetched_q;
        loaded_d  = loaded_q;
        bit_d     = bit_out;
        active_d  = tx_active;
        strobe_d  = 1'b0;
        done_d    = 1'b0;
        under_d   = 1'b0;

        if (accept) begin
            hold_d    = in_if.in_data;
            full_d    = 1'b1;
            fetched_d = fetched_q + 8'd1;
        end

        if (state_q == IDLE) begin
            if (start && len != '0) begin
                state_d   = PREAMBLE;
                len_d     = len;
                idx_d     = '0;
                full_d    = 1'b0;
                fetched_d = '0;
                loaded_d  = '0;
                bit_d     = 1'b1;
                active_d  = 1'b1;
                strobe_d  = 1'b1;
            end
        end else if (wrap) begin
            strobe_d = 1'b1;
            if (!last_bit) begin
                bit_d = (state_q == PREAMBLE) ? ~bit_out : sh_q[31];
                sh_d  = {sh_q[30:0], 1'b0};
                idx_d = idx_q + 16'd1;
            end else begin
                idx_d = '0;
                case (state_q)
                    PREAMBLE: begin
                        state_d = SYNC;
                        bit_d   = SYNC_ALIGNED[31];
                        sh_d    = {SYNC_ALIGNED[30:0], 1'b0};
                    end
                    SYNC: begin
                        state_d = LENGTH;
                        bit_d   = len_q[7];
                        sh_d    = {len_q[6:0], 25'b0};
                    end
                    default: begin
                        // End of a byte in LENGTH/PAYLOAD: finish, load the next byte, or abort.
                        if (state_q == PAYLOAD && loaded_q == len_q) begin
                            state_d  = IDLE;
                            bit_d    = IDLE_LEVEL;
                            active_d = 1'b0;
                            strobe_d = 1'b0;
                            done_d   = 1'b1;
                        end else if (full_q) begin
                            state_d  = PAYLOAD;
                            bit_d    = hold_q[7];
                            sh_d     = {hold_q[6:0], 25'b0};
                            loaded_d = loaded_q + 8'd1;
                            if (!accept)
                                full_d = 1'b0;
                        end else begin
                            state_d  = IDLE;
                            bit_d    = IDLE_LEVEL;
                            active_d = 1'b0;
                            strobe_d = 1'b0;
                            under_d  = 1'b1;
                        end
                    end
                endcase
            end
        end
    end

    always_ff @(posedge bb_clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            len_q      <= '0;
            sh_q       <= '0;
            idx_q      <= '0;
            hold_q     <= '0;
            full_q     <= 1'b0;
            fetched_q  <= '0;
            loaded_q   <= '0;
            bit_out    <= IDLE_LEVEL;
            tx_active  <= 1'b0;
            bit_strobe <= 1'b0;
            done       <= 1'b0;
            underrun   <= 1'b0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            sh_q       <= sh_d;
            idx_q      <= idx_d;
            hold_q     <= hold_d;
            full_q     <= full_d;
            fetched_q  <= fetched_d;
            loaded_q   <= loaded_d;
            bit_out    <= bit_d;
            tx_active  <= active_d;
            bit_strobe <= strobe_d;
            done       <= done_d;
            underrun   <= under_d;
        end
    end
endmodule

// File: tb/tb_fsk_tx_framer.sv
// Self-checking bench for fsk_tx_framer: constant frame table, hand sequences, random frames vs. model.
module tb_fsk_tx_framer;
    localparam int          BP  = 4;
    localparam int          PRE = 8;
    localparam int          SL  = 8;
    localparam logic [31:0] SW  = 32'h0000_00D3;
    localparam int          HDR = PRE + SL + 8;

    typedef struct {
        int          n;
        int          k;
        logic [7:0]  b0;
        logic [7:0]  b1;
        int          nbits;
        logic [47:0] bits;
        bit          ex_done;
        bit          ex_und;
    } rec_t;

    logic       bb_clk = 1'b0;
    logic       rst    = 1'b1;
    logic       start  = 1'b0;
    logic [7:0] len    = '0;
    logic       bit_out, tx_active, bit_strobe, done, underrun;

    int         errors = 0;
    int         checks = 0;
    logic [7:0] pay [256];
    bit         exp_q [$];

    fsk_tx_framer_if ifc ();

    fsk_tx_framer #(
        .BIT_PERIOD    (BP),
        .PREAMBLE_BITS (PRE),
        .SYNC_LEN      (SL),
        .SYNC_WORD     (SW),
        .IDLE_LEVEL    (1'b0)
    ) dut (
        .bb_clk     (bb_clk),
        .rst        (rst),
        .start      (start),
        .len        (len),
        .in_if      (ifc),
        .bit_out    (bit_out),
        .tx_active  (tx_active),
        .bit_strobe (bit_strobe),
        .done       (done),
        .underrun   (underrun)
    );

    always #5 bb_clk = ~bb_clk;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0d, want %0d", name, got, want);
        end
    endtask

    // Reference bit stream of a frame from the framing rules; only the first k payload bytes go on air.
    function automatic void build_exp(input int n, input int k);
        int         nb;
        logic [31:0] sw;
        logic [7:0]  ln;
        logic [7:0]  b;
        nb = (k < n) ? k : n;
        sw = SW;
        ln = 8'(n);
        exp_q.delete();
        for (int i = 0; i < PRE; i++) exp_q.push_back(i % 2 == 0);
        for (int i = SL - 1; i >= 0; i--) exp_q.push_back(sw[i]);
        for (int i = 7; i >= 0; i--) exp_q.push_back(ln[i]);
        for (int j = 0; j < nb; j++) begin
            b = pay[j];
            for (int i = 7; i >= 0; i--) exp_q.push_back(b[i]);
        end
    endfunction

    // Runs one frame from start to done/underrun and checks it against exp_q.
    task automatic run_frame(input string tag, input int n, input int k, input bit always_valid,
                             input bit ex_done, input bit ex_und);
        bit got_q [$];
        int act_cnt = 0, strobes = 0, since = 0, timing_bad = 0, hold_bad = 0;
        int accepted = 0, occ = 0, limit, mism = -1;
        bit ended = 0, was_done = 0, was_und = 0, end_ok = 0, first_ok = 0;
        bit prev_act = 0, prev_bit = 0, acc;
        limit = (HDR + 8 * n) * BP + 40;
        start = 1'b1;
        len   = 8'(n);
        ifc.in_valid = 1'b0;
        ifc.in_data  = pay[0];
        for (int cyc = 0; cyc < limit && !ended; cyc++) begin
            acc = ifc.in_valid && ifc.in_ready;
            @(negedge bb_clk);
            start = 1'b0;
            if (acc) begin
                if (occ != 0 || accepted >= n) hold_bad++;
                accepted++;
                occ++;
            end
            if (cyc == 0) first_ok = tx_active && bit_out && bit_strobe;
            if (done || underrun) begin
                ended    = 1;
                was_done = done;
                was_und  = underrun;
                end_ok   = prev_act && !tx_active && (bit_out == 1'b0) && !bit_strobe;
            end else begin
                if (tx_active) act_cnt++;
                if (bit_strobe) begin
                    if (strobes > 0 && since != BP) timing_bad++;
                    strobes++;
                    since = 0;
                    got_q.push_back(bit_out);
                    if (strobes > HDR && (strobes - HDR - 1) % 8 == 0) occ--;
                end else if (tx_active && bit_out != prev_bit) begin
                    timing_bad++;
                end
                since++;
                prev_act = tx_active;
                prev_bit = bit_out;
            end
            if (always_valid) begin
                ifc.in_valid = 1'b1;
                ifc.in_data  = pay[accepted];
            end else begin
                if (acc) ifc.in_valid = 1'b0;
                if (!ifc.in_valid && accepted < k && $urandom_range(0, 1) == 1) begin
                    ifc.in_valid = 1'b1;
                    ifc.in_data  = pay[accepted];
                end
            end
        end
        ifc.in_valid = 1'b0;
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            if (mism < 0 && got_q[i] != exp_q[i]) mism = i;
        chk({tag, " ended"}, 64'(ended), 64'd1);
        chk({tag, " first_bit"}, 64'(first_ok), 64'd1);
        chk({tag, " nbits"}, 64'(got_q.size()), 64'(exp_q.size()));
        chk({tag, " bits_first_mismatch"}, 64'(mism), 64'(-1));
        chk({tag, " active_cycles"}, 64'(act_cnt), 64'(exp_q.size() * BP));
        chk({tag, " done"}, 64'(was_done), 64'(ex_done));
        chk({tag, " underrun"}, 64'(was_und), 64'(ex_und));
        chk({tag, " end_cycle"}, 64'(end_ok), 64'd1);
        chk({tag, " bit_timing_errs"}, 64'(timing_bad), 64'd0);
        chk({tag, " hold_errs"}, 64'(hold_bad), 64'd0);
        chk({tag, " accepted"}, 64'(accepted), 64'(always_valid ? n : ((k < n) ? k : n)));
        @(negedge bb_clk);
        chk({tag, " single_pulse"}, {61'd0, done, underrun, tx_active}, 64'd0);
    endtask

    initial begin
        rec_t tbl [5];
        int   bad, strobes, n, k;
        logic [47:0] bv;

        tbl[0] = '{n:1, k:1, b0:8'hA5, b1:8'h00, nbits:32, bits:48'h0000_AAD3_01A5, ex_done:1, ex_und:0};
        tbl[1] = '{n:0, k:0, b0:8'h00, b1:8'h00, nbits:0,  bits:48'h0,              ex_done:0, ex_und:0};
        tbl[2] = '{n:2, k:1, b0:8'h3C, b1:8'h00, nbits:32, bits:48'h0000_AAD3_023C, ex_done:0, ex_und:1};
        tbl[3] = '{n:2, k:2, b0:8'h5A, b1:8'hC3, nbits:40, bits:48'h00AA_D302_5AC3, ex_done:1, ex_und:0};
        tbl[4] = '{n:1, k:0, b0:8'h00, b1:8'h00, nbits:24, bits:48'h0000_00AA_D301, ex_done:0, ex_und:1};

        ifc.in_valid = 1'b0;
        ifc.in_data  = '0;
        repeat (3) @(negedge bb_clk);
        chk("reset_outputs", {58'd0, bit_out, tx_active, bit_strobe, done, underrun, ifc.in_ready}, 64'd0);
        rst = 1'b0;
        @(negedge bb_clk);
        chk("idle_outputs", {58'd0, bit_out, tx_active, bit_strobe, done, underrun, ifc.in_ready}, 64'd0);

        for (int t = 0; t < 5; t++) begin
            pay[0] = tbl[t].b0;
            pay[1] = tbl[t].b1;
            if (tbl[t].n == 0) begin
                start = 1'b1;
                len   = '0;
                bad   = 0;
                for (int c = 0; c < 12; c++) begin
                    @(negedge bb_clk);
                    start = 1'b0;
                    if (tx_active || ifc.in_ready || bit_strobe || done || underrun || bit_out) bad++;
                end
                chk("len0_ignored", 64'(bad), 64'd0);
            end else begin
                bv = tbl[t].bits;
                exp_q.delete();
                for (int i = 0; i < tbl[t].nbits; i++) exp_q.push_back(bv[tbl[t].nbits - 1 - i]);
                run_frame($sformatf("tbl%0d", t), tbl[t].n, tbl[t].k, 1'b0, tbl[t].ex_done, tbl[t].ex_und);
            end
            repeat (2) @(negedge bb_clk);
        end

        // Back-to-back: second start lands the cycle after done.
        pay[0] = 8'h81;
        build_exp(1, 1);
        run_frame("b2b_a", 1, 1, 1'b0, 1'b1, 1'b0);
        pay[0] = 8'h4E;
        pay[1] = 8'hF0;
        build_exp(2, 2);
        run_frame("b2b_b", 2, 2, 1'b0, 1'b1, 1'b0);

        // Reset during the third payload bit, then a clean frame.
        len          = 8'd2;
        start        = 1'b1;
        ifc.in_valid = 1'b1;
        ifc.in_data  = 8'h96;
        strobes      = 0;
        for (int c = 0; c < 400 && strobes < HDR + 3; c++) begin
            @(negedge bb_clk);
            start = 1'b0;
            if (bit_strobe) strobes++;
        end
        chk("rst_reached_payload", 64'(strobes), 64'(HDR + 3));
        @(posedge bb_clk);
        #2 rst = 1'b1;
        #1 chk("rst_async_outputs", {58'd0, bit_out, tx_active, bit_strobe, done, underrun, ifc.in_ready}, 64'd0);
        ifc.in_valid = 1'b0;
        @(negedge bb_clk);
        chk("rst_hold_outputs", {58'd0, bit_out, tx_active, bit_strobe, done, underrun, ifc.in_ready}, 64'd0);
        rst = 1'b0;
        @(negedge bb_clk);
        pay[0] = 8'h2D;
        build_exp(1, 1);
        run_frame("after_rst", 1, 1, 1'b0, 1'b1, 1'b0);

        // Backpressure: source always valid, only len bytes may be taken.
        for (int j = 0; j < 8; j++) pay[j] = 8'($urandom);
        build_exp(3, 3);
        run_frame("backpressure", 3, 3, 1'b1, 1'b1, 1'b0);

        for (int r = 0; r < 10; r++) begin
            n = $urandom_range(1, 6);
            k = ($urandom_range(0, 3) == 0) ? $urandom_range(0, n - 1) : n;
            for (int j = 0; j < n; j++) pay[j] = 8'($urandom);
            build_exp(n, k);
            repeat ($urandom_range(0, 3)) @(negedge bb_clk);
            run_frame($sformatf("rnd%0d", r), n, k, 1'b0, k >= n, k < n);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
